fetch_stage: RTL and testbench

PC register plus IF/ID pipeline register for the five-stage core. Issues instruction-ROM requests over a req/ack handshake and presents fetched instructions to ID. Consumes the pipeline hazard unit's `stop_PC`, `stop_IF_ID` and `flush_IF_ID` controls and the EX-stage redirect (`npc_op`/`npc`). Tolerates variable ROM latency by inserting bubbles.

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-ROM request/acknowledge bus between the fetch stage (master) and the ROM (slave).
interface fetch_stage_if;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_ack;
  logic [31:0] irom_rdata;

  modport master (
    output irom_req,
    output irom_addr,
    input  irom_ack,
    input  irom_rdata
  );

  modport slave (
    input  irom_req,
    input  irom_addr,
    output irom_ack,
    output irom_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register with a req/ack instruction-ROM port.
// Define FETCH_PERF_EN to build the redirect/bubble performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stop_PC,
  input  logic          stop_IF_ID,
  input  logic          flush_IF_ID,
  input  logic          npc_op,
  input  logic [31:0]   npc,
  fetch_stage_if.master irom,
  output logic [31:0]   pc_ID,
  output logic [31:0]   pc4_ID,
  output logic [31:0]   inst_ID,
  output logic          valid_ID,
  output logic [31:0]   redirect_cnt,
  output logic [31:0]   bubble_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  logic        load_real;
  logic [31:0] load_word;

  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic        valid_id_q, valid_id_d;

  logic        stall;
  assign stall = stop_PC | stop_IF_ID;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      buf_q      <= NOP_INST;
      pc_id_q    <= '0;
      pc4_id_q   <= '0;
      inst_id_q  <= NOP_INST;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      inst_id_q  <= inst_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  // Next-state, PC and fetch-address logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    load_real = 1'b0;
    load_word = irom.irom_rdata;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (irom.irom_ack) begin
          if (npc_op) begin
            state_d = StReq;
          end else if (stall) begin
            buf_d   = irom.irom_rdata;
            state_d = StHold;
          end else begin
            load_real = 1'b1;
            pc_d      = pc_q + 32'd4;
          end
        end else if (npc_op) begin
          state_d = StDrop;
        end
      end
      StHold: begin
        if (npc_op) begin
          state_d = StReq;
        end else if (!stall) begin
          load_real = 1'b1;
          load_word = buf_q;
          pc_d      = pc_q + 32'd4;
          state_d   = StReq;
        end
      end
      StDrop: if (irom.irom_ack) state_d = StReq;
      default: state_d = StIdle;
    endcase
    if (npc_op) pc_d = {npc[31:2], 2'b00};
    // A dropped request keeps presenting its original address until acknowledged.
    addr_d = (state_d == StDrop) ? addr_q : pc_d;
  end

  // IF/ID next values: flush beats load beats hold; otherwise a bubble.
  always_comb begin
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    inst_id_d  = inst_id_q;
    valid_id_d = valid_id_q;
    if (flush_IF_ID || (!load_real && !stop_IF_ID)) begin
      pc_id_d    = '0;
      pc4_id_d   = '0;
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
    end else if (load_real) begin
      pc_id_d    = pc_q;
      pc4_id_d   = pc_q + 32'd4;
      inst_id_d  = load_word;
      valid_id_d = 1'b1;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    irom.irom_req  = (state_q == StReq) || (state_q == StDrop);
    irom.irom_addr = addr_q;
    pc_ID          = pc_id_q;
    pc4_ID         = pc4_id_q;
    inst_ID        = inst_id_q;
    valid_ID       = valid_id_q;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] bubble_cnt_q;
  logic        bubble_inc;

  assign bubble_inc = !flush_IF_ID && !load_real && !stop_IF_ID;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      if (npc_op)     redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (bubble_inc) bubble_cnt_q   <= bubble_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign bubble_cnt   = bubble_cnt_q;
`else
  assign redirect_cnt = '0;
  assign bubble_cnt   = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a variable-latency ROM responder, a flag-based reference model
// compared every cycle, and hand-computed spot checks for each scenario.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stop_PC = 1'b0, stop_IF_ID = 1'b0, flush_IF_ID = 1'b0, npc_op = 1'b0;
  logic [31:0] npc = '0;
  logic [31:0] pc_ID, pc4_ID, inst_ID, redirect_cnt, bubble_cnt;
  logic        valid_ID;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stop_PC      (stop_PC),
    .stop_IF_ID   (stop_IF_ID),
    .flush_IF_ID  (flush_IF_ID),
    .npc_op       (npc_op),
    .npc          (npc),
    .irom         (bus),
    .pc_ID        (pc_ID),
    .pc4_ID       (pc4_ID),
    .inst_ID      (inst_ID),
    .valid_ID     (valid_ID),
    .redirect_cnt (redirect_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;
  int lat = 1;
  int rom_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Reference model: flags for "waiting after reset", "word parked", "discarding a request".
  logic [31:0] m_pc, m_addr, m_buf, m_pc_id, m_pc4_id, m_inst_id, m_redir, m_bub, m_word;
  logic        m_req, m_valid, m_idle, m_hold, m_drop, m_ack, m_deliver;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0;
      m_idle = 1'b1; m_hold = 1'b0; m_drop = 1'b0; m_buf = NOP;
      m_pc_id = '0; m_pc4_id = '0; m_inst_id = NOP; m_valid = 1'b0;
      m_redir = '0; m_bub = '0;
    end else begin
      m_ack     = m_req && bus.irom_ack;
      m_deliver = 1'b0;
      m_word    = NOP;
      if (!npc_op && !stop_PC && !stop_IF_ID) begin
        if (m_hold) begin
          m_deliver = 1'b1; m_word = m_buf;
        end else if (m_ack && !m_drop) begin
          m_deliver = 1'b1; m_word = rom(m_addr);
        end
      end
      if (flush_IF_ID) begin
        m_pc_id = '0; m_pc4_id = '0; m_inst_id = NOP; m_valid = 1'b0;
      end else if (m_deliver) begin
        m_pc_id = m_pc; m_pc4_id = m_pc + 32'd4; m_inst_id = m_word; m_valid = 1'b1;
      end else if (!stop_IF_ID) begin
        m_pc_id = '0; m_pc4_id = '0; m_inst_id = NOP; m_valid = 1'b0;
        m_bub = m_bub + 32'd1;
      end
      if (npc_op) m_redir = m_redir + 32'd1;
      if (m_idle) m_idle = 1'b0;
      else if (m_hold) begin
        if (npc_op || !(stop_PC || stop_IF_ID)) m_hold = 1'b0;
      end else if (m_drop) begin
        if (m_ack) m_drop = 1'b0;
      end else if (m_ack && !npc_op && (stop_PC || stop_IF_ID)) begin
        m_hold = 1'b1; m_buf = rom(m_addr);
      end else if (!m_ack && npc_op) m_drop = 1'b1;
      if (npc_op) m_pc = {npc[31:2], 2'b00};
      else if (m_deliver) m_pc = m_pc + 32'd4;
      if (!m_drop) m_addr = m_pc;
      m_req = !m_idle && !m_hold;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("irom_req", {31'b0, bus.irom_req}, {31'b0, m_req});
      chk("irom_addr", bus.irom_addr, m_addr);
      chk("pc_ID", pc_ID, m_pc_id);
      chk("pc4_ID", pc4_ID, m_pc4_id);
      chk("inst_ID", inst_ID, m_inst_id);
      chk("valid_ID", {31'b0, valid_ID}, {31'b0, m_valid});
`ifdef FETCH_PERF_EN
      chk("redirect_cnt", redirect_cnt, m_redir);
      chk("bubble_cnt", bubble_cnt, m_bub);
`else
      chk("redirect_cnt", redirect_cnt, 32'h0);
      chk("bubble_cnt", bubble_cnt, 32'h0);
`endif
    end
  end

  // ROM responder: acks once a request has been up for 'lat' cycles, then one edge.
  task automatic tick();
    if (bus.irom_req && rom_cnt == lat - 1) begin
      bus.irom_ack   = 1'b1;
      bus.irom_rdata = rom(bus.irom_addr);
      rom_cnt        = 0;
    end else begin
      bus.irom_ack   = 1'b0;
      bus.irom_rdata = 32'hDEAD_BEEF;
      rom_cnt        = bus.irom_req ? rom_cnt + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
`ifdef FETCH_PERF_EN
    chk(name, act, exp);
`else
    chk(name, act, 32'h0);
`endif
  endtask

  initial begin
    bus.irom_ack   = 1'b0;
    bus.irom_rdata = '0;

    // Reset values and single-cycle ROM streaming.
    rst = 1'b1; tick(); check_en = 1'b1;
    chk("rst_req", {31'b0, bus.irom_req}, 32'h0);
    chk("rst_addr", bus.irom_addr, 32'h0);
    chk("rst_inst", inst_ID, 32'h13);
    chk("rst_valid", {31'b0, valid_ID}, 32'h0);
    rst = 1'b0; tick();
    chk("first_req", {31'b0, bus.irom_req}, 32'h1);
    tick();
    chk("stream0_inst", inst_ID, 32'hA000_0000);
    chk("stream0_valid", {31'b0, valid_ID}, 32'h1);
    tick(); tick();
    chk("stream2_pc", pc_ID, 32'h8);
    chk("stream2_addr", bus.irom_addr, 32'hC);

    // Three-cycle ROM: two bubbles per fetch.
    lat = 3; tick();
    chk("lat3_bubble_inst", inst_ID, 32'h13);
    chk("lat3_bubble_valid", {31'b0, valid_ID}, 32'h0);
    tick(); tick();
    chk("lat3_pc", pc_ID, 32'hC);
    chk_cnt("lat3_bubbles_a", bubble_cnt, 32'd3);
    tick(); tick(); tick();
    chk("lat3_pc2", pc_ID, 32'h10);
    chk_cnt("lat3_bubbles_b", bubble_cnt, 32'd5);

    // Stall while the 0x8 ack arrives.
    lat = 1; rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick(); tick();
    chk("stall_pre_pc", pc_ID, 32'h4);
    stop_PC = 1'b1; stop_IF_ID = 1'b1; tick();
    chk("stall_hold_inst", inst_ID, 32'hA000_0004);
    chk("stall_req_low", {31'b0, bus.irom_req}, 32'h0);
    tick();
    chk("stall_hold_pc", pc_ID, 32'h4);
    stop_PC = 1'b0; stop_IF_ID = 1'b0; tick();
    chk("stall_rel_pc", pc_ID, 32'h8);
    chk("stall_rel_inst", inst_ID, 32'hA000_0008);
    chk("stall_no_refetch", bus.irom_addr, 32'hC);

    // Redirect while the 0x10 request is outstanding.
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("drop_pre_addr", bus.irom_addr, 32'h10);
    lat = 3; npc_op = 1'b1; npc = 32'h103; tick();
    npc_op = 1'b0;
    chk("drop_old_addr", bus.irom_addr, 32'h10);
    chk("drop_req", {31'b0, bus.irom_req}, 32'h1);
    tick(); tick();
    chk("drop_new_addr", bus.irom_addr, 32'h100);
    chk("drop_discard", {31'b0, valid_ID}, 32'h0);
    tick(); tick(); tick();
    chk("drop_target_pc", pc_ID, 32'h100);
    chk("drop_target_inst", inst_ID, 32'hA000_0100);
    chk_cnt("drop_redirects", redirect_cnt, 32'd1);
    chk_cnt("drop_bubbles", bubble_cnt, 32'd6);

    // Flush with stop_IF_ID and an ack, then redirect with an ack.
    lat = 1; flush_IF_ID = 1'b1; stop_IF_ID = 1'b1; tick();
    flush_IF_ID = 1'b0; stop_IF_ID = 1'b0;
    chk("flush_valid", {31'b0, valid_ID}, 32'h0);
    chk("flush_pc", pc_ID, 32'h0);
    tick();
    chk("flush_buf_pc", pc_ID, 32'h104);
    npc_op = 1'b1; npc = 32'h40; tick();
    npc_op = 1'b0;
    chk("redir_ack_addr", bus.irom_addr, 32'h40);
    tick();
    chk("redir_ack_inst", inst_ID, 32'hA000_0040);
    chk_cnt("redir_count2", redirect_cnt, 32'd2);

    // Reset in the middle of a request, then refetch from 0.
    lat = 3; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_req", {31'b0, bus.irom_req}, 32'h0);
    chk("midrst_inst", inst_ID, 32'h13);
    chk_cnt("midrst_bubbles", bubble_cnt, 32'd0);
    tick();
    chk("midrst_refetch", bus.irom_addr, 32'h0);

    // PC wrap.
    lat = 1; npc_op = 1'b1; npc = 32'hFFFF_FFFF; tick();
    npc_op = 1'b0;
    chk("wrap_addr", bus.irom_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc4", pc4_ID, 32'h0);
    chk("wrap_next_addr", bus.irom_addr, 32'h0);
    tick(); tick();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
